loadstore: RTL and testbench

LOADSTORE -- requirements
Module: loadstore

---
 rtl/loadstore.sv | 165 ++++++++++++++++
 tb/tb_loadstore.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loadstore.sv
// Load/store stage: forwards ALU results to write-back and runs single-beat
// pipelined Wishbone B4 transfers for loads and stores.
module loadstore (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic [31:0] result_i,
    input  logic        ls_enable_i,
    input  logic        ls_write_i,
    input  logic        ls_unsigned_load_i,
    input  logic [31:0] ls_write_data_i,
    input  logic [3:0]  ls_sel_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,

    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned RADR_W = 5;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t              state_q;
    logic                unsigned_q;
    logic                reg_write_q;
    logic [RADR_W-1:0]   reg_addr_q;

    logic                is_byte_c;
    logic                is_half_c;
    logic                is_word_c;
    logic [BYTE_W-1:0]   lane_byte_c;
    logic [HALF_W-1:0]   lane_half_c;
    logic [DATA_W-1:0]   load_data_c;

    // Ready is a pure decode of the state register.
    assign input_ready_o = (state_q == IDLE);

    // Lane selection and sign/zero extension of load data.
    always_comb begin
        is_byte_c   = 1'b0;
        is_half_c   = 1'b0;
        is_word_c   = 1'b0;
        lane_byte_c = '0;
        lane_half_c = '0;
        load_data_c = '0;
        case (wb_sel_o)
            4'b0001: begin is_byte_c = 1'b1; lane_byte_c = wb_dat_i[7:0];   end
            4'b0010: begin is_byte_c = 1'b1; lane_byte_c = wb_dat_i[15:8];  end
            4'b0100: begin is_byte_c = 1'b1; lane_byte_c = wb_dat_i[23:16]; end
            4'b1000: begin is_byte_c = 1'b1; lane_byte_c = wb_dat_i[31:24]; end
            4'b0011: begin is_half_c = 1'b1; lane_half_c = wb_dat_i[15:0];  end
            4'b1100: begin is_half_c = 1'b1; lane_half_c = wb_dat_i[31:16]; end
            4'b1111: is_word_c = 1'b1;
            default: ;
        endcase
        if (is_byte_c) begin
            load_data_c = unsigned_q
                ? {{(DATA_W-BYTE_W){1'b0}}, lane_byte_c}
                : {{(DATA_W-BYTE_W){lane_byte_c[BYTE_W-1]}}, lane_byte_c};
        end else if (is_half_c) begin
            load_data_c = unsigned_q
                ? {{(DATA_W-HALF_W){1'b0}}, lane_half_c}
                : {{(DATA_W-HALF_W){lane_half_c[HALF_W-1]}}, lane_half_c};
        end else if (is_word_c) begin
            load_data_c = wb_dat_i;
        end
    end

    // State and all registered outputs; reset abandons any open bus cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            unsigned_q     <= 1'b0;
            reg_write_q    <= 1'b0;
            reg_addr_q     <= '0;
            wb_adr_o       <= '0;
            wb_dat_o       <= '0;
            wb_sel_o       <= '0;
            wb_we_o        <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_cyc_o       <= 1'b0;
            output_valid_o <= 1'b0;
            reg_write_o    <= 1'b0;
            reg_addr_o     <= '0;
            reg_data_o     <= '0;
        end else begin
            output_valid_o <= 1'b0;
            reg_write_o    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (input_valid_i) begin
                        if (ls_enable_i) begin
                            state_q     <= REQUEST;
                            wb_adr_o    <= result_i;
                            wb_dat_o    <= ls_write_data_i;
                            wb_sel_o    <= SEL_W'(ls_sel_i);
                            wb_we_o     <= ls_write_i;
                            wb_stb_o    <= 1'b1;
                            wb_cyc_o    <= 1'b1;
                            unsigned_q  <= ls_unsigned_load_i;
                            reg_write_q <= reg_write_i;
                            reg_addr_q  <= reg_addr_i;
                        end else begin
                            output_valid_o <= 1'b1;
                            reg_write_o    <= reg_write_i;
                            reg_addr_o     <= reg_addr_i;
                            reg_data_o     <= result_i;
                        end
                    end
                end
                REQUEST: begin
                    if (!wb_stall_i) begin
                        wb_stb_o <= 1'b0;
                        if (wb_ack_i) begin
                            state_q        <= IDLE;
                            wb_cyc_o       <= 1'b0;
                            output_valid_o <= 1'b1;
                            reg_write_o    <= reg_write_q;
                            reg_addr_o     <= reg_addr_q;
                            reg_data_o     <= wb_we_o ? '0 : load_data_c;
                        end else begin
                            state_q <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (wb_ack_i) begin
                        state_q        <= IDLE;
                        wb_cyc_o       <= 1'b0;
                        wb_stb_o       <= 1'b0;
                        output_valid_o <= 1'b1;
                        reg_write_o    <= reg_write_q;
                        reg_addr_o     <= reg_addr_q;
                        reg_data_o     <= wb_we_o ? '0 : load_data_c;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loadstore.sv
// Directed bench for loadstore: the bench acts as a Wishbone slave and checks
// write-back and bus outputs one cycle at a time against hand-computed values.
module tb_loadstore;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic [31:0] result_i;
    logic        ls_enable_i;
    logic        ls_write_i;
    logic        ls_unsigned_load_i;
    logic [31:0] ls_write_data_i;
    logic [3:0]  ls_sel_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_stall_i;
    logic        output_valid_o;
    logic        reg_write_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o;

    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;

    always #5 clk_i = ~clk_i;

    loadstore dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .input_valid_i      (input_valid_i),
        .input_ready_o      (input_ready_o),
        .result_i           (result_i),
        .ls_enable_i        (ls_enable_i),
        .ls_write_i         (ls_write_i),
        .ls_unsigned_load_i (ls_unsigned_load_i),
        .ls_write_data_i    (ls_write_data_i),
        .ls_sel_i           (ls_sel_i),
        .reg_write_i        (reg_write_i),
        .reg_addr_i         (reg_addr_i),
        .wb_adr_o           (wb_adr_o),
        .wb_dat_o           (wb_dat_o),
        .wb_sel_o           (wb_sel_o),
        .wb_we_o            (wb_we_o),
        .wb_stb_o           (wb_stb_o),
        .wb_cyc_o           (wb_cyc_o),
        .wb_dat_i           (wb_dat_i),
        .wb_ack_i           (wb_ack_i),
        .wb_stall_i         (wb_stall_i),
        .output_valid_o     (output_valid_o),
        .reg_write_o        (reg_write_o),
        .reg_addr_o         (reg_addr_o),
        .reg_data_o         (reg_data_o)
    );

    // Counts cycles with a write-back pulse, sampled mid-cycle.
    always @(negedge clk_i) if (output_valid_o === 1'b1) valid_cnt++;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        input_valid_i = 0; result_i = 0; ls_enable_i = 0; ls_write_i = 0;
        ls_unsigned_load_i = 0; ls_write_data_i = 0; ls_sel_i = 0;
        reg_write_i = 0; reg_addr_i = 0;
        wb_dat_i = 0; wb_ack_i = 0; wb_stall_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, output_valid_o, reg_write_o} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got %b required 00000",
                {wb_cyc_o, wb_stb_o, wb_we_o, output_valid_o, reg_write_o});
        end
        checks++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o, reg_addr_o, reg_data_o} !== '0) begin
            failures++; $display("FAIL reset_data adr=%h dat=%h sel=%b raddr=%h rdata=%h required all 0",
                wb_adr_o, wb_dat_o, wb_sel_o, reg_addr_o, reg_data_o);
        end
        step(); step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (input_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_ready got %b required 1", input_ready_o);
        end
        step();
        checks++;
        if (output_valid_o !== 1'b0 || input_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_idle valid=%b ready=%b required 0/1", output_valid_o, input_ready_o);
        end
    endtask

    task automatic test_alu_pass();
        int v0;
        v0 = valid_cnt;
        input_valid_i = 1; ls_enable_i = 0; result_i = 32'h1234_5678;
        reg_write_i = 1; reg_addr_i = 5'd5;
        step();
        idle_inputs();
        checks++;
        if (output_valid_o !== 1'b1 || reg_data_o !== 32'h1234_5678 || reg_addr_o !== 5'd5 || reg_write_o !== 1'b1) begin
            failures++; $display("FAIL alu_wb valid=%b data=%h addr=%0d we=%b required 1/12345678/5/1",
                output_valid_o, reg_data_o, reg_addr_o, reg_write_o);
        end
        checks++;
        if (wb_cyc_o !== 1'b0 || input_ready_o !== 1'b1) begin
            failures++; $display("FAIL alu_no_bus cyc=%b ready=%b required 0/1", wb_cyc_o, input_ready_o);
        end
        step();
        checks++;
        if (output_valid_o !== 1'b0 || reg_write_o !== 1'b0) begin
            failures++; $display("FAIL alu_idle valid=%b we=%b required 0/0", output_valid_o, reg_write_o);
        end
        step();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL alu_pulses got %0d required 1", valid_cnt - v0);
        end
    endtask

    task automatic test_signed_byte_load();
        int v0;
        v0 = valid_cnt;
        input_valid_i = 1; ls_enable_i = 1; ls_write_i = 0; ls_unsigned_load_i = 0;
        result_i = 32'h0000_0103; ls_sel_i = 4'b1000; reg_write_i = 1; reg_addr_i = 5'd7;
        step();
        idle_inputs();
        checks++;
        if (wb_cyc_o !== 1 || wb_stb_o !== 1 || wb_we_o !== 0 || wb_adr_o !== 32'h103 || wb_sel_o !== 4'b1000) begin
            failures++; $display("FAIL sbl_req cyc=%b stb=%b we=%b adr=%h sel=%b required 1/1/0/103/1000",
                wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o);
        end
        checks++;
        if (input_ready_o !== 1'b0) begin
            failures++; $display("FAIL sbl_ready_req got %b required 0", input_ready_o);
        end
        step();
        checks++;
        if (wb_cyc_o !== 1 || wb_stb_o !== 0 || input_ready_o !== 0 || output_valid_o !== 0) begin
            failures++; $display("FAIL sbl_wait1 cyc=%b stb=%b ready=%b valid=%b required 1/0/0/0",
                wb_cyc_o, wb_stb_o, input_ready_o, output_valid_o);
        end
        wb_ack_i = 1; wb_dat_i = 32'h80FF_0000;
        step();
        wb_ack_i = 0; wb_dat_i = 0;
        checks++;
        if (output_valid_o !== 1 || reg_data_o !== 32'hFFFF_FF80 || reg_addr_o !== 5'd7 || reg_write_o !== 1) begin
            failures++; $display("FAIL sbl_data valid=%b data=%h addr=%0d we=%b required 1/ffffff80/7/1",
                output_valid_o, reg_data_o, reg_addr_o, reg_write_o);
        end
        checks++;
        if (wb_cyc_o !== 0 || wb_stb_o !== 0 || input_ready_o !== 1) begin
            failures++; $display("FAIL sbl_done cyc=%b stb=%b ready=%b required 0/0/1", wb_cyc_o, wb_stb_o, input_ready_o);
        end
        step();
        checks++;
        if (output_valid_o !== 0 || reg_write_o !== 0 || valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL sbl_pulse valid=%b we=%b pulses=%0d required 0/0/1",
                output_valid_o, reg_write_o, valid_cnt - v0);
        end
    endtask

    task automatic test_unsigned_half_load();
        input_valid_i = 1; ls_enable_i = 1; ls_write_i = 0; ls_unsigned_load_i = 1;
        result_i = 32'h0000_0202; ls_sel_i = 4'b1100; reg_write_i = 1; reg_addr_i = 5'd9;
        wb_stall_i = 1;
        step();
        idle_inputs();
        wb_stall_i = 1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) wb_stall_i = 0;
            checks++;
            if (wb_stb_o !== 1 || wb_cyc_o !== 1 || wb_adr_o !== 32'h202 || wb_sel_o !== 4'b1100) begin
                failures++; $display("FAIL uhl_stall_cycle%0d stb=%b cyc=%b adr=%h sel=%b required 1/1/202/1100",
                    c, wb_stb_o, wb_cyc_o, wb_adr_o, wb_sel_o);
            end
            step();
        end
        checks++;
        if (wb_stb_o !== 0 || wb_cyc_o !== 1) begin
            failures++; $display("FAIL uhl_wait stb=%b cyc=%b required 0/1", wb_stb_o, wb_cyc_o);
        end
        wb_ack_i = 1; wb_dat_i = 32'hBEEF_0000;
        step();
        wb_ack_i = 0; wb_dat_i = 0;
        checks++;
        if (output_valid_o !== 1 || reg_data_o !== 32'h0000_BEEF || reg_addr_o !== 5'd9) begin
            failures++; $display("FAIL uhl_data valid=%b data=%h addr=%0d required 1/0000beef/9",
                output_valid_o, reg_data_o, reg_addr_o);
        end
        step();
    endtask

    task automatic test_word_store();
        int v0;
        v0 = valid_cnt;
        input_valid_i = 1; ls_enable_i = 1; ls_write_i = 1; result_i = 32'h0000_0200;
        ls_write_data_i = 32'hCAFE_BABE; ls_sel_i = 4'b1111; reg_write_i = 0; reg_addr_i = 5'd0;
        step();
        idle_inputs();
        checks++;
        if (wb_we_o !== 1 || wb_stb_o !== 1 || wb_adr_o !== 32'h200 || wb_dat_o !== 32'hCAFE_BABE || wb_sel_o !== 4'hF) begin
            failures++; $display("FAIL ws_req we=%b stb=%b adr=%h dat=%h sel=%h required 1/1/200/cafebabe/f",
                wb_we_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        wb_ack_i = 1;
        step();
        wb_ack_i = 0;
        checks++;
        if (output_valid_o !== 1 || reg_write_o !== 0 || reg_data_o !== 32'h0) begin
            failures++; $display("FAIL ws_done valid=%b we=%b data=%h required 1/0/0",
                output_valid_o, reg_write_o, reg_data_o);
        end
        checks++;
        if (wb_stb_o !== 0 || wb_cyc_o !== 0 || input_ready_o !== 1) begin
            failures++; $display("FAIL ws_bus stb=%b cyc=%b ready=%b required 0/0/1", wb_stb_o, wb_cyc_o, input_ready_o);
        end
        step();
        checks++;
        if (valid_cnt - v0 !== 1) begin
            failures++; $display("FAIL ws_pulses got %0d required 1", valid_cnt - v0);
        end
    endtask

    task automatic test_reset_mid_txn();
        int v0;
        v0 = valid_cnt;
        input_valid_i = 1; ls_enable_i = 1; ls_write_i = 0; result_i = 32'h0000_0300;
        ls_sel_i = 4'b1111; reg_write_i = 1; reg_addr_i = 5'd11;
        step();
        idle_inputs();
        step();
        checks++;
        if (wb_cyc_o !== 1 || wb_stb_o !== 0) begin
            failures++; $display("FAIL rst_mid_wait cyc=%b stb=%b required 1/0", wb_cyc_o, wb_stb_o);
        end
        rst_i = 1;
        #1;
        checks++;
        if (wb_cyc_o !== 0 || wb_adr_o !== 0 || wb_sel_o !== 0 || output_valid_o !== 0 || input_ready_o !== 1) begin
            failures++; $display("FAIL rst_mid_async cyc=%b adr=%h sel=%b valid=%b ready=%b required 0/0/0/0/1",
                wb_cyc_o, wb_adr_o, wb_sel_o, output_valid_o, input_ready_o);
        end
        step();
        rst_i = 0;
        wb_ack_i = 1; wb_dat_i = 32'h1111_2222;
        step();
        wb_ack_i = 0; wb_dat_i = 0;
        checks++;
        if (output_valid_o !== 0 || reg_write_o !== 0 || reg_data_o !== 0 || wb_cyc_o !== 0 || input_ready_o !== 1) begin
            failures++; $display("FAIL rst_mid_late_ack valid=%b we=%b data=%h cyc=%b ready=%b required 0/0/0/0/1",
                output_valid_o, reg_write_o, reg_data_o, wb_cyc_o, input_ready_o);
        end
        step();
        checks++;
        if (valid_cnt - v0 !== 0) begin
            failures++; $display("FAIL rst_mid_pulses got %0d required 0", valid_cnt - v0);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        input_valid_i = 1; ls_enable_i = 0; result_i = 32'h0000_0011; reg_write_i = 1; reg_addr_i = 5'd1;
        step();
        checks++;
        if (output_valid_o !== 1 || reg_data_o !== 32'h11 || reg_addr_o !== 5'd1) begin
            failures++; $display("FAIL b2b_first valid=%b data=%h addr=%0d required 1/11/1",
                output_valid_o, reg_data_o, reg_addr_o);
        end
        ls_enable_i = 1; ls_write_i = 0; ls_sel_i = 4'b1111; result_i = 32'h0000_0040; reg_addr_i = 5'd2;
        step();
        ls_enable_i = 0; result_i = 32'h0000_0033; reg_addr_i = 5'd3; ls_sel_i = 4'b0000;
        checks++;
        if (wb_stb_o !== 1 || wb_adr_o !== 32'h40 || output_valid_o !== 0 || input_ready_o !== 0) begin
            failures++; $display("FAIL b2b_load_req stb=%b adr=%h valid=%b ready=%b required 1/40/0/0",
                wb_stb_o, wb_adr_o, output_valid_o, input_ready_o);
        end
        step();
        checks++;
        if (output_valid_o !== 0 || input_ready_o !== 0 || wb_adr_o !== 32'h40 || wb_sel_o !== 4'hF) begin
            failures++; $display("FAIL b2b_hold valid=%b ready=%b adr=%h sel=%h required 0/0/40/f",
                output_valid_o, input_ready_o, wb_adr_o, wb_sel_o);
        end
        wb_ack_i = 1; wb_dat_i = 32'h5566_7788;
        step();
        wb_ack_i = 0; wb_dat_i = 0;
        checks++;
        if (output_valid_o !== 1 || reg_data_o !== 32'h5566_7788 || reg_addr_o !== 5'd2 || input_ready_o !== 1) begin
            failures++; $display("FAIL b2b_load_done valid=%b data=%h addr=%0d ready=%b required 1/55667788/2/1",
                output_valid_o, reg_data_o, reg_addr_o, input_ready_o);
        end
        step();
        idle_inputs();
        checks++;
        if (output_valid_o !== 1 || reg_data_o !== 32'h33 || reg_addr_o !== 5'd3) begin
            failures++; $display("FAIL b2b_third valid=%b data=%h addr=%0d required 1/33/3",
                output_valid_o, reg_data_o, reg_addr_o);
        end
        step();
        checks++;
        if (output_valid_o !== 0 || valid_cnt - v0 !== 3) begin
            failures++; $display("FAIL b2b_pulses valid=%b pulses=%0d required 0/3", output_valid_o, valid_cnt - v0);
        end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_signed_byte_load();
        test_unsigned_half_load();
        test_word_store();
        test_reset_mid_txn();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
